mine_spawner: RTL
=================

// Module: mine_spawner
// PURPOSE
//  Upstream placement engine for the mine field. On request, draws pseudo-random grid cells
//  from an internal LFSR and rejects any cell on the snake body, on the head, or on another
//  active mine. Serial FSM, one body segment checked per cycle. Returns one legal cell to the
//  mine manager over a req/valid handshake, or reports failure after a bounded number of draws.
// PARAMETERS
//  X_MIN      1        lowest legal x cell (6-bit)
//  X_MAX      38       highest legal x cell
//  Y_MIN      1        lowest legal y cell (5-bit)
//  Y_MAX      28       highest legal y cell
//  MAX_TRIES  15       candidate draws before giving up (1..255)
//  SEED       16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  spawn_req    in   1   one-cycle request, sampled only in IDLE
//  spawn_idx    in   2   mine slot to fill (0..2), latched with spawn_req
//  head_x       in   6   snake head x
//  head_y       in   6   snake head y
//  is_exist     in   16  body segment valid mask
//  body_x       in   96  segment i x = body_x[6i+5:6i]
//  body_y       in   96  segment i y = body_y[6i+5:6i]
//  mine_x       in   18  mine k x = mine_x[6k+5:6k]
//  mine_y       in   15  mine k y = mine_y[5k+4:5k]
//  mine_active  in   3   active mask of existing mines
//  busy         out  1   high from the cycle after an accepted req until DONE/FAIL exits
//  spawn_valid  out  1   one-cycle pulse, cell is legal
//  spawn_fail   out  1   one-cycle pulse, MAX_TRIES exhausted
//  spawn_x      out  6   result x, held until next valid
//  spawn_y      out  5   result y, held until next valid
//  spawn_slot   out  2   latched spawn_idx, held with spawn_x/y
// BEHAVIOUR
//  - Reset: state IDLE, busy/spawn_valid/spawn_fail=0, spawn_x/spawn_y/spawn_slot=0,
//    try counter=0, LFSR=SEED.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in all states.
//  - States: IDLE -> DRAW -> SCAN -> HCHK -> DONE -> IDLE; SCAN/HCHK reject -> DRAW;
//    DRAW with tries==MAX_TRIES -> FAIL -> IDLE.
//  - IDLE: spawn_req=1 latches spawn_idx, clears tries, goes to DRAW. Req ignored elsewhere.
//  - DRAW: cand_x=lfsr[13:8], cand_y=lfsr[4:0]; tries+1. If cand_x or cand_y is outside
//    [MIN,MAX], stay in DRAW. This counts as a try. Else seg=0 and go to SCAN.
//  - SCAN: one segment per cycle, seg 0..15. Segment hits when is_exist[seg] and
//    {body_x,body_y} equals {cand_x,{1'b0,cand_y}}. Hit -> DRAW next cycle.
//    seg==15 with no hit -> HCHK.
//  - HCHK: reject on a head hit, or on a hit with mine k where mine_active[k]=1 and k!=slot.
//    Otherwise go to DONE.
//  - DONE: spawn_valid=1 and spawn_x/y/slot update in the same cycle; next cycle IDLE.
//  - FAIL: spawn_fail=1 for one cycle; spawn_x/y unchanged; next cycle IDLE.
//  - Minimum latency: req at cycle 0, DRAW at 1, SCAN at 2..17, HCHK at 18,
//    spawn_valid at 19.
//  - busy falls in the cycle after DONE/FAIL, so a new req is accepted 1 cycle after valid.
//  - spawn_valid and spawn_fail are never high together.
//  - Inputs are not registered. The mine manager holds body/head/mine inputs stable while
//    busy=1; changes mid-scan only affect the segments not yet compared.
//  - Async reset mid-scan aborts immediately to reset values with no valid/fail pulse.
// CONFIGURATION
//  - SPAWN_HEAD_GUARD_EN defined: HCHK also rejects any cell with |dx|<=1 and |dy|<=1 of the
//    head, i.e. a 3x3 keep-out zone. Unsigned compare; no wrap at grid edges.
//  - Undefined: only the exact head cell is rejected.
// TESTING
//  - Reset, then idle 5 cycles: all outputs 0; LFSR sequence matches a model from 16'hACE1.
//  - Empty board (is_exist=0, mine_active=0), req slot 2: spawn_valid at cycle 19,
//    spawn_slot=2, x in [1,38], y in [1,28].
//  - Force candidate onto segment 3 (model-predicted cell, is_exist[3]=1): reject after the
//    segment-3 compare, redraw, final cell differs from segment 3.
//  - Fill all legal cells via a model-driven occupancy (MAX_TRIES=4): spawn_fail one cycle,
//    no spawn_valid, busy drops next cycle.
//  - Candidate equals mine 1 with mine_active=3'b010, slot 0: rejected. Same with slot 1:
//    accepted, since own slot is ignored.
//  - SPAWN_HEAD_GUARD_EN, head=(10,10), candidate (11,9): rejected. Without the macro: accepted.
//  - rst low at cycle 8 of a scan: busy=0 immediately; no pulse; a fresh req after release
//    completes normally.

Source files
------------

// File: rtl/mine_spawner.sv
// mine_spawner: picks a free grid cell for a new mine.
//
// A request in IDLE latches the target slot. The FSM then draws candidate
// cells from a free-running 16-bit LFSR, scans the 16 body segments one per
// cycle, then checks the head and the other active mines. A legal cell is
// returned with a one-cycle spawn_valid pulse. spawn_fail pulses instead once
// MAX_TRIES draws have been used up.
//
// Optional feature: define SPAWN_HEAD_GUARD_EN to reject every cell in the
// 3x3 zone around the head, not only the head cell itself.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   spawn_req, spawn_idx     one-cycle request and target mine slot (0..2)
//   head_x, head_y           snake head cell
//   is_exist, body_x, body_y body segment valid mask and packed coordinates
//   mine_x, mine_y           packed coordinates of the existing mines
//   mine_active              active mask of the existing mines
//   busy                     request in progress
//   spawn_valid, spawn_fail  one-cycle result pulses
//   spawn_x, spawn_y         accepted cell, held until the next valid
//   spawn_slot               slot of the accepted cell, held with spawn_x/y
module mine_spawner #(
    parameter int unsigned X_MIN     = 1,
    parameter int unsigned X_MAX     = 38,
    parameter int unsigned Y_MIN     = 1,
    parameter int unsigned Y_MAX     = 28,
    parameter int unsigned MAX_TRIES = 15,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic [1:0]  spawn_idx,
    input  logic [5:0]  head_x,
    input  logic [5:0]  head_y,
    input  logic [15:0] is_exist,
    input  logic [95:0] body_x,
    input  logic [95:0] body_y,
    input  logic [17:0] mine_x,
    input  logic [14:0] mine_y,
    input  logic [2:0]  mine_active,
    output logic        busy,
    output logic        spawn_valid,
    output logic        spawn_fail,
    output logic [5:0]  spawn_x,
    output logic [4:0]  spawn_y,
    output logic [1:0]  spawn_slot
);

    localparam int unsigned XW     = 6;
    localparam int unsigned YW     = 5;
    localparam int unsigned TRY_W  = 8;
    localparam int unsigned SEG_N  = 16;
    localparam int unsigned MINE_N = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_SCAN,
        S_HCHK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       lfsr, lfsr_nxt;
    logic [XW-1:0]     cand_x, cand_x_nxt;
    logic [YW-1:0]     cand_y, cand_y_nxt;
    logic [3:0]        seg, seg_nxt;
    logic [TRY_W-1:0]  tries, tries_nxt;
    logic [1:0]        slot, slot_nxt;
    logic              busy_nxt, valid_nxt, fail_nxt;
    logic [XW-1:0]     spawn_x_nxt;
    logic [YW-1:0]     spawn_y_nxt;
    logic [1:0]        spawn_slot_nxt;

    logic [XW-1:0]     seg_bx [SEG_N];
    logic [5:0]        seg_by [SEG_N];
    logic [XW-1:0]     draw_x;
    logic [YW-1:0]     draw_y;
    logic              draw_ok;
    logic              seg_hit;
    logic              head_hit;
    logic              mine_hit;

    // Unpack the segment coordinate buses for indexing by the scan counter.
    always_comb begin
        for (int i = 0; i < int'(SEG_N); i++) begin
            seg_bx[i] = body_x[6*i +: 6];
            seg_by[i] = body_y[6*i +: 6];
        end
    end

    // Candidate taken straight from the LFSR, range-checked against the grid.
    assign draw_x  = lfsr[13:8];
    assign draw_y  = lfsr[4:0];
    assign draw_ok = (draw_x >= XW'(X_MIN)) && (draw_x <= XW'(X_MAX)) &&
                     (draw_y >= YW'(Y_MIN)) && (draw_y <= YW'(Y_MAX));

    // Body y is 6 bits wide while the grid y is 5 bits.
    assign seg_hit = is_exist[seg] && (seg_bx[seg] == cand_x) &&
                     (seg_by[seg] == {1'b0, cand_y});

`ifdef SPAWN_HEAD_GUARD_EN
    // 3x3 keep-out around the head; 7-bit unsigned compares, no wrap at edges.
    logic dx_near, dy_near;
    assign dx_near  = ({1'b0, cand_x} + 7'd1 >= {1'b0, head_x}) &&
                      ({1'b0, head_x} + 7'd1 >= {1'b0, cand_x});
    assign dy_near  = ({2'b0, cand_y} + 7'd1 >= {1'b0, head_y}) &&
                      ({1'b0, head_y} + 7'd1 >= {2'b0, cand_y});
    assign head_hit = dx_near && dy_near;
`else
    assign head_hit = (head_x == cand_x) && (head_y == {1'b0, cand_y});
`endif

    // The slot being refilled is ignored so its stale coordinates never block.
    always_comb begin
        mine_hit = 1'b0;
        for (int k = 0; k < int'(MINE_N); k++) begin
            if (mine_active[k] && (2'(k) != slot) &&
                (mine_x[6*k +: 6] == cand_x) && (mine_y[5*k +: 5] == cand_y)) begin
                mine_hit = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        cand_x_nxt = cand_x;
        cand_y_nxt = cand_y;
        seg_nxt    = seg;
        tries_nxt  = tries;
        slot_nxt   = slot;

        case (state)
            S_IDLE: begin
                if (spawn_req) begin
                    slot_nxt  = spawn_idx;
                    tries_nxt = '0;
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (tries == TRY_W'(MAX_TRIES)) begin
                    state_nxt = S_FAIL;
                end else begin
                    tries_nxt  = tries + TRY_W'(1);
                    cand_x_nxt = draw_x;
                    cand_y_nxt = draw_y;
                    // Out-of-range draws stay here and still consume a try.
                    if (draw_ok) begin
                        seg_nxt   = '0;
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (seg_hit) begin
                    state_nxt = S_DRAW;
                end else if (seg == 4'(SEG_N - 1)) begin
                    state_nxt = S_HCHK;
                end else begin
                    seg_nxt = seg + 4'd1;
                end
            end
            S_HCHK: begin
                state_nxt = (head_hit || mine_hit) ? S_DRAW : S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered so they line up with the state they describe.
        busy_nxt       = (state_nxt != S_IDLE);
        valid_nxt      = (state_nxt == S_DONE);
        fail_nxt       = (state_nxt == S_FAIL);
        spawn_x_nxt    = (state_nxt == S_DONE) ? cand_x : spawn_x;
        spawn_y_nxt    = (state_nxt == S_DONE) ? cand_y : spawn_y;
        spawn_slot_nxt = (state_nxt == S_DONE) ? slot   : spawn_slot;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            cand_x      <= '0;
            cand_y      <= '0;
            seg         <= '0;
            tries       <= '0;
            slot        <= '0;
            busy        <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_fail  <= 1'b0;
            spawn_x     <= '0;
            spawn_y     <= '0;
            spawn_slot  <= '0;
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_nxt;
            cand_x      <= cand_x_nxt;
            cand_y      <= cand_y_nxt;
            seg         <= seg_nxt;
            tries       <= tries_nxt;
            slot        <= slot_nxt;
            busy        <= busy_nxt;
            spawn_valid <= valid_nxt;
            spawn_fail  <= fail_nxt;
            spawn_x     <= spawn_x_nxt;
            spawn_y     <= spawn_y_nxt;
            spawn_slot  <= spawn_slot_nxt;
        end
    end

endmodule
